// File: rtl/multi_lane_block_solver.sv
// multi_lane_block_solver
//   Searches nonces [nonce_start, nonce_end] for one job using NUM_LANES
//   lockstep sha_core pairs (midstate continuation, then outer hash). A lane
//   wins when its byte-reversed double hash is strictly below target.
//   Optional macro SOLVER_CONTINUE_EN: after a found result is accepted,
//   keep searching the same job from result_nonce+1.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   job_valid/job_ready         job handshake (ready only in IDLE)
//   midstate, header_leftovers  job header data; target = threshold
//   nonce_start, nonce_end      inclusive search range
//   abort                       cancel the current job (ignored in IDLE)
//   result_valid/result_ready   result handshake
//   result_found, result_nonce  outcome (nonce is 0 when not found)
//   hashes_done                 valid lane-nonces tested, saturating
//   state_out                   FSM state
module sha_core (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] state_in,  // must stay stable until done
  input  logic [511:0] block,     // sampled only on start
  output logic         done,
  output logic [255:0] hash
);
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // v[7]=a ... v[0]=h; w[0] is W_t of the current round
  logic [7:0][31:0]  v_q, v_d, v_n, st;
  logic [15:0][31:0] w_q, w_d;
  logic [5:0]        rnd_q, rnd_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [255:0]      hash_q, hash_d;
  logic [31:0]       t1, t2, wn;

  assign st = state_in;

  always_comb begin
    t1  = v_q[0] + (ror(v_q[3], 6) ^ ror(v_q[3], 11) ^ ror(v_q[3], 25))
        + ((v_q[3] & v_q[2]) ^ (~v_q[3] & v_q[1])) + K[rnd_q] + w_q[0];
    t2  = (ror(v_q[7], 2) ^ ror(v_q[7], 13) ^ ror(v_q[7], 22))
        + ((v_q[7] & v_q[6]) ^ (v_q[7] & v_q[5]) ^ (v_q[6] & v_q[5]));
    v_n = {t1 + t2, v_q[7], v_q[6], v_q[5], v_q[4] + t1, v_q[3], v_q[2], v_q[1]};
    wn  = (ror(w_q[14], 17) ^ ror(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
        + (ror(w_q[1], 7) ^ ror(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
    v_d = v_q; w_d = w_q; rnd_d = rnd_q; busy_d = busy_q; done_d = 1'b0; hash_d = hash_q;
    if (start) begin
      // a restart overrides any round still in flight
      v_d = state_in; rnd_d = '0; busy_d = 1'b1;
      for (int i = 0; i < 16; i++) w_d[i] = block[511-32*i -: 32];
    end else if (busy_q) begin
      v_d = v_n; w_d = {wn, w_q[15:1]}; rnd_d = rnd_q + 6'd1;
      if (rnd_q == 6'd63) begin
        busy_d = 1'b0; done_d = 1'b1;
        for (int i = 0; i < 8; i++) hash_d[32*i +: 32] = st[i] + v_n[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0; w_q <= '0; rnd_q <= '0; busy_q <= 1'b0; done_q <= 1'b0; hash_q <= '0;
    end else begin
      v_q <= v_d; w_q <= w_d; rnd_q <= rnd_d; busy_q <= busy_d; done_q <= done_d; hash_q <= hash_d;
    end
  end

  assign done = done_q;
  assign hash = hash_q;
endmodule

module multi_lane_block_solver #(
  parameter int NUM_LANES = 4,
  parameter int LANE_BITS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [255:0] midstate,
  input  logic [95:0]  header_leftovers,
  input  logic [255:0] target,
  input  logic [31:0]  nonce_start,
  input  logic [31:0]  nonce_end,
  input  logic         abort,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         result_found,
  output logic [31:0]  result_nonce,
  output logic [31:0]  hashes_done,
  output logic [2:0]   state_out
);
  localparam int CW = LANE_BITS + 1;  // wide enough to hold NUM_LANES
  localparam logic [255:0] SHA_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  typedef enum logic [2:0] {
    IDLE = 3'd0, FIRST_PRE = 3'd1, FIRST = 3'd2, SECOND_PRE = 3'd3,
    SECOND = 3'd4, CHECK = 3'd5, REPORT = 3'd6
  } state_t;

  function automatic logic [255:0] brev(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  state_t                      state_q, state_d;
  logic [255:0]                mid_q, mid_d, tgt_q, tgt_d;
  logic [95:0]                 left_q, left_d;
  logic [31:0]                 end_q, end_d, cur_q, cur_d, hashes_q, hashes_d, rnonce_q, rnonce_d;
  logic                        rvalid_q, rvalid_d, rfound_q, rfound_d;
  logic [NUM_LANES-1:0]        seen_q, seen_d, in_done, out_done, lane_vld, lane_ok;
  logic [NUM_LANES-1:0][255:0] inner_q, inner_d, in_hash, out_hash;
  logic [CW-1:0]               n_vld, win;
  logic                        any_ok, exhaust;
  logic [32:0]                 hsum;

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [31:0] nonce;
    assign nonce = cur_q + 32'(k);
    // nonce goes into the header little-endian, as in the block header format
    sha_core u_inner (
      .clk(clk), .rst_n(rst_n), .start(state_q == FIRST_PRE), .state_in(mid_q),
      .block({left_q, nonce[7:0], nonce[15:8], nonce[23:16], nonce[31:24], 8'h80, 360'b0, 16'h0280}),
      .done(in_done[k]), .hash(in_hash[k]));
    sha_core u_outer (
      .clk(clk), .rst_n(rst_n), .start(state_q == SECOND_PRE), .state_in(SHA_IV),
      .block({inner_q[k], 8'h80, 232'b0, 16'h0100}),
      .done(out_done[k]), .hash(out_hash[k]));
    // 33-bit compare: lanes past nonce_end never wrap back to 0
    assign lane_vld[k] = ({1'b0, cur_q} + 33'(k)) <= {1'b0, end_q};
    assign lane_ok[k]  = lane_vld[k] && (brev(out_hash[k]) < tgt_q);
  end

  // valid-lane count and lowest winning lane
  always_comb begin
    n_vld = '0; any_ok = 1'b0; win = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      n_vld = n_vld + CW'(lane_vld[k]);
      if (lane_ok[k]) begin any_ok = 1'b1; win = CW'(k); end
    end
  end

  assign hsum    = {1'b0, hashes_q} + 33'(n_vld);
  assign exhaust = ({1'b0, cur_q} + 33'(NUM_LANES)) > {1'b0, end_q};

  always_comb begin
    state_d = state_q; mid_d = mid_q; left_d = left_q; tgt_d = tgt_q; end_d = end_q;
    cur_d = cur_q; hashes_d = hashes_q; rnonce_d = rnonce_q; rvalid_d = rvalid_q;
    rfound_d = rfound_q; seen_d = seen_q; inner_d = inner_q;
    unique case (state_q)
      IDLE: if (job_valid) begin
        mid_d = midstate; left_d = header_leftovers; tgt_d = target; end_d = nonce_end;
        cur_d = nonce_start; hashes_d = '0;
        if (nonce_start > nonce_end) begin
          state_d = REPORT; rvalid_d = 1'b1; rfound_d = 1'b0; rnonce_d = '0;
        end else state_d = FIRST_PRE;
      end
      FIRST_PRE:  begin seen_d = '0; state_d = FIRST; end
      FIRST: begin
        seen_d = seen_q | in_done;
        if (&seen_d) begin inner_d = in_hash; state_d = SECOND_PRE; end
      end
      SECOND_PRE: begin seen_d = '0; state_d = SECOND; end
      SECOND: begin
        seen_d = seen_q | out_done;
        if (&seen_d) state_d = CHECK;
      end
      CHECK: begin
        hashes_d = hsum[32] ? 32'hFFFF_FFFF : hsum[31:0];
        if (any_ok) begin
          state_d = REPORT; rvalid_d = 1'b1; rfound_d = 1'b1; rnonce_d = cur_q + 32'(win);
        end else if (exhaust) begin
          state_d = REPORT; rvalid_d = 1'b1; rfound_d = 1'b0; rnonce_d = '0;
        end else begin
          cur_d = cur_q + 32'(NUM_LANES); state_d = FIRST_PRE;
        end
      end
      REPORT: if (result_ready) begin
        rvalid_d = 1'b0; state_d = IDLE;
`ifdef SOLVER_CONTINUE_EN
        if (rfound_q) begin
          if (rnonce_q < end_q) begin
            cur_d = rnonce_q + 32'd1; state_d = FIRST_PRE;
          end else begin
            // winner was the last nonce: the range is now exhausted
            state_d = REPORT; rvalid_d = 1'b1; rfound_d = 1'b0; rnonce_d = '0;
          end
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // abort beats any handshake or CHECK decision taken this cycle
    if (abort && state_q != IDLE) begin
      state_d = IDLE; rvalid_d = 1'b0; hashes_d = hashes_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE; mid_q <= '0; left_q <= '0; tgt_q <= '0; end_q <= '0; cur_q <= '0;
      hashes_q <= '0; rnonce_q <= '0; rvalid_q <= 1'b0; rfound_q <= 1'b0;
      seen_q <= '0; inner_q <= '0;
    end else begin
      state_q <= state_d; mid_q <= mid_d; left_q <= left_d; tgt_q <= tgt_d; end_q <= end_d;
      cur_q <= cur_d; hashes_q <= hashes_d; rnonce_q <= rnonce_d; rvalid_q <= rvalid_d;
      rfound_q <= rfound_d; seen_q <= seen_d; inner_q <= inner_d;
    end
  end

  assign job_ready    = (state_q == IDLE);
  assign result_valid = rvalid_q;
  assign result_found = rfound_q;
  assign result_nonce = rnonce_q;
  assign hashes_done  = hashes_q;
  assign state_out    = state_q;
endmodule

// File: tb/tb_multi_lane_block_solver.sv
// Bench for multi_lane_block_solver (NUM_LANES=4): table of jobs with
// expected results queued on a scoreboard, plus hand-written abort/reset
// sequences and, with SOLVER_CONTINUE_EN, the continue-search sequence.
module tb_multi_lane_block_solver;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic         job_valid = 1'b0, job_ready, abort = 1'b0;
  logic [255:0] midstate = '0, target = '0;
  logic [95:0]  header_leftovers = '0;
  logic [31:0]  nonce_start = '0, nonce_end = '0;
  logic         result_valid, result_ready = 1'b0, result_found;
  logic [31:0]  result_nonce, hashes_done;
  logic [2:0]   state_out;

  always #5 clk = ~clk;

  multi_lane_block_solver #(.NUM_LANES(4), .LANE_BITS(2)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .midstate(midstate), .header_leftovers(header_leftovers), .target(target),
    .nonce_start(nonce_start), .nonce_end(nonce_end), .abort(abort),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_found(result_found), .result_nonce(result_nonce),
    .hashes_done(hashes_done), .state_out(state_out));

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    logic [63:0] y;
    y = {x, x} >> n;
    return y[31:0];
  endfunction

  // reference compression, used to derive the genesis midstate
  function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    {a, b, c, d, e, f, g, h} = st;
    for (int i = 0; i < 64; i++) begin
      t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[i] + w[i];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
            st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
  endfunction

  typedef struct {
    logic [255:0] mid; logic [95:0] left; logic [255:0] tgt;
    logic [31:0] ns, ne; logic found; logic [31:0] nonce, hashes;
  } vec_t;
  typedef struct { logic found; logic [31:0] nonce, hashes; bit chk_h; } exp_t;

  exp_t sb[$];
  vec_t tbl[7];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  task automatic drive_job(input vec_t v, input bit push);
    exp_t e;
    chk("job_ready_before_job", 32'(job_ready), 32'd1);
    midstate = v.mid; header_leftovers = v.left; target = v.tgt;
    nonce_start = v.ns; nonce_end = v.ne; job_valid = 1'b1;
    @(negedge clk);
    job_valid = 1'b0;
    if (push) begin
      e.found = v.found; e.nonce = v.nonce; e.hashes = v.hashes; e.chk_h = 1'b1;
      sb.push_back(e);
    end
  endtask

  // wait for a result, compare with scoreboard head, then handshake
  task automatic collect(input string tag);
    exp_t e;
    int n = 0;
    while (!result_valid && n < 3000) begin @(negedge clk); n++; end
    if (sb.size() == 0) begin
      checks++; errors++; $display("FAIL %s_scoreboard: got empty expected entry", tag);
      return;
    end
    e = sb.pop_front();
    if (!result_valid) begin
      checks++; errors++; $display("FAIL %s_timeout: got no result expected result_valid=1", tag);
      return;
    end
    chk({tag, "_found"}, 32'(result_found), 32'(e.found));
    chk({tag, "_nonce"}, result_nonce, e.nonce);
    if (e.chk_h) chk({tag, "_hashes"}, hashes_done, e.hashes);
    @(negedge clk);
    chk({tag, "_valid_held"}, 32'(result_valid), 32'd1);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
`ifndef SOLVER_CONTINUE_EN
    chk({tag, "_valid_dropped"}, 32'(result_valid), 32'd0);
    chk({tag, "_ready_after"}, 32'(job_ready), 32'd1);
`endif
  endtask

  // wait until a given state is reached with a given hashes_done
  task automatic wait_state(input logic [2:0] s, input logic [31:0] h, input string tag);
    int n = 0;
    while (!(state_out == s && hashes_done == h) && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_reached"}, 32'(state_out == s && hashes_done == h), 32'd1);
  endtask

  initial begin
    logic [255:0] ones, gen_mid, gen_tgt;
    logic [511:0] gen_blk0;
    vec_t v;
    int   seen;
    ones     = '1;
    gen_blk0 = {32'h01000000, 256'h0,
                224'h3ba3edfd7a7b12b27ac72c3e67768f617fc81bc3888a51323a9fb8aa};
    gen_mid  = sha_compress(IV, gen_blk0);
    gen_tgt  = 256'h0000_0000_ffff << 208;   // bits 0x1d00ffff

    //             mid      left                         tgt      start          end            found nonce          hashes
    tbl[0] = '{IV,      96'h0123456789abcdef01234567, ones,    32'h100,       32'h1FF,       1'b1, 32'h100,       32'd4};
    tbl[1] = '{IV,      96'h0123456789abcdef01234567, '0,      32'd10,        32'd14,        1'b0, 32'h0,         32'd5};
    tbl[2] = '{gen_mid, 96'h4b1e5e4a29ab5f49ffff001d, gen_tgt, 32'h7C2BAC1A,  32'h7C2BAC20,  1'b1, 32'h7C2BAC1D,  32'd4};
    tbl[3] = '{IV,      96'h0,                        '0,      32'hFFFFFFFE,  32'hFFFFFFFF,  1'b0, 32'h0,         32'd2};
    tbl[4] = '{IV,      96'h0,                        ones,    32'd5,         32'd4,         1'b0, 32'h0,         32'd0};
    tbl[5] = '{IV,      96'hfeedface0000000011112222, ones,    32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1, 32'hFFFFFFFF,  32'd1};
    tbl[6] = '{IV,      96'h0,                        ones,    32'd0,         32'd7,         1'b1, 32'h0,         32'd4};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_job_ready", 32'(job_ready), 32'd1);
    chk("rst_found", 32'(result_found), 32'd0);
    chk("rst_nonce", result_nonce, 32'd0);
    chk("rst_hashes", hashes_done, 32'd0);

    for (int i = 0; i < 7; i++) begin
      drive_job(tbl[i], 1'b1);
      collect($sformatf("vec%0d", i));
`ifdef SOLVER_CONTINUE_EN
      if (tbl[i].found) begin abort = 1'b1; @(negedge clk); abort = 1'b0; @(negedge clk); end
`endif
    end

    // abort during SECOND of the second round, result_ready held low
    v = tbl[1]; v.ns = 32'd0; v.ne = 32'd100;
    drive_job(v, 1'b0);
    wait_state(3'd4, 32'd4, "abort_second");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", 32'(state_out), 32'd0);
    chk("abort_valid", 32'(result_valid), 32'd0);
    chk("abort_job_ready", 32'(job_ready), 32'd1);
    chk("abort_hashes_hold", hashes_done, 32'd4);
    seen = 0;
    repeat (300) begin @(negedge clk); if (result_valid) seen++; end
    chk("abort_no_result", 32'(seen), 32'd0);

    // new job accepted the cycle right after an abort
    v = tbl[0]; v.ns = 32'h20; v.ne = 32'h30;
    drive_job(v, 1'b0);
    wait_state(3'd2, 32'd0, "abort2_first");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    v.nonce = 32'h20; v.found = 1'b1; v.hashes = 32'd4;
    drive_job(v, 1'b1);
    chk("abort_new_job_state", 32'(state_out), 32'd1);
    collect("after_abort");
`ifdef SOLVER_CONTINUE_EN
    abort = 1'b1; @(negedge clk); abort = 1'b0; @(negedge clk);
`endif

    // abort wins over a simultaneous result handshake
    v = tbl[0]; v.ns = 32'h40; v.ne = 32'h50;
    drive_job(v, 1'b0);
    seen = 0;
    while (!result_valid && seen < 3000) begin @(negedge clk); seen++; end
    chk("abort_rep_valid", 32'(result_valid), 32'd1);
    abort = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0; result_ready = 1'b0;
    chk("abort_rep_state", 32'(state_out), 32'd0);
    chk("abort_rep_valid_low", 32'(result_valid), 32'd0);

    // synchronous reset in FIRST of the second round
    v = tbl[1]; v.ns = 32'd0; v.ne = 32'd100;
    drive_job(v, 1'b0);
    wait_state(3'd2, 32'd4, "reset_first");
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_state", 32'(state_out), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    chk("midrst_found", 32'(result_found), 32'd0);
    chk("midrst_nonce", result_nonce, 32'd0);
    chk("midrst_hashes", hashes_done, 32'd0);
    chk("midrst_job_ready", 32'(job_ready), 32'd1);

`ifdef SOLVER_CONTINUE_EN
    // continue search: every nonce of 0..7 reported in order, then exhaustion
    begin
      exp_t e;
      drive_job(tbl[6], 1'b0);
      for (int k = 0; k < 9; k++) begin
        e.found = (k < 8); e.nonce = (k < 8) ? 32'(k) : 32'd0; e.hashes = '0; e.chk_h = 1'b0;
        sb.push_back(e);
        collect($sformatf("cont%0d", k));
      end
      @(negedge clk);
      chk("cont_idle", 32'(state_out), 32'd0);
    end
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
